// File: rtl/alu_reg_pkg.sv
// Shared opcode constants and helpers for the registered ALU.
// sel[3:2] picks the unit; sel[1:0] picks the sub-operation within it.
package alu_reg_pkg;

  localparam logic [1:0] UNIT_LOGIC = 2'b00;
  localparam logic [1:0] UNIT_ARITH = 2'b01;
  // Shift occupies both 2'b10 and 2'b11; only bit 1 is decoded.
  localparam logic [1:0] UNIT_SHIFT = 2'b10;

  localparam logic [1:0] LOGIC_AND     = 2'b00;
  localparam logic [1:0] LOGIC_AND_ALT = 2'b01;
  localparam logic [1:0] LOGIC_OR      = 2'b10;
  localparam logic [1:0] LOGIC_XOR     = 2'b11;

  localparam logic [1:0] ARITH_ADD = 2'b00;
  localparam logic [1:0] ARITH_SUB = 2'b01;
  localparam logic [1:0] ARITH_INC = 2'b10;
  localparam logic [1:0] ARITH_DEC = 2'b11;

  // Carry-in needed by the shared adder for each arithmetic sub-op.
  function automatic logic arith_cin(input logic [1:0] op);
    return op[1] ^ op[0];
  endfunction

  function automatic logic is_shift_unit(input logic [1:0] unit);
    return unit[1] == UNIT_SHIFT[1];
  endfunction

endpackage

// File: rtl/alu_reg_arith.sv
// Combinational add/sub/inc/dec built on a single adder a + operand + cin.
// For sub and dec the carry is the inverted borrow.
module alu_reg_arith
  import alu_reg_pkg::*;
#(
  parameter int unsigned SIZE = 5
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic [1:0]      op,
  output logic [SIZE-1:0] sum,
  output logic            carry
);

  logic [SIZE-1:0] operand;
  logic            cin;
  logic [SIZE:0]   full;

  always_comb begin
    operand = b;
    unique case (op)
      ARITH_ADD: operand = b;
      ARITH_SUB: operand = ~b;
      ARITH_INC: operand = '0;
      ARITH_DEC: operand = '1;
      default:   operand = b;
    endcase
  end

  assign cin   = arith_cin(op);
  assign full  = {1'b0, a} + {1'b0, operand} + {{SIZE{1'b0}}, cin};
  assign sum   = full[SIZE-1:0];
  assign carry = full[SIZE];

endmodule

// File: rtl/alu_reg.sv
// Registered ALU: logic, arithmetic and arithmetic-shift-right units feeding one output register.
// The carry bit always reflects the adder for sel[1:0], whichever unit drives the result.
module alu_reg
  import alu_reg_pkg::*;
#(
  parameter int unsigned SIZE = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic [3:0]      sel,
  output logic [SIZE:0]   out,
  output logic            out_valid
);

  logic [SIZE-1:0] arith_sum;
  logic            arith_carry;
  logic [SIZE-1:0] logic_res;
  logic [SIZE-1:0] shift_res;
  logic [SIZE-1:0] result;

  logic [SIZE:0]   out_q;
  logic            valid_q;

  alu_reg_arith #(
    .SIZE(SIZE)
  ) u_arith (
    .a    (a),
    .b    (b),
    .op   (sel[1:0]),
    .sum  (arith_sum),
    .carry(arith_carry)
  );

  always_comb begin
    logic_res = a & b;
    unique case (sel[1:0])
      LOGIC_AND, LOGIC_AND_ALT: logic_res = a & b;
      LOGIC_OR:                 logic_res = a | b;
      LOGIC_XOR:                logic_res = a ^ b;
      default:                  logic_res = a & b;
    endcase
  end

  // Sign bit is replicated into the top position.
  assign shift_res = {a[SIZE-1], a[SIZE-1:1]};

  always_comb begin
    result = logic_res;
    if (is_shift_unit(sel[3:2])) begin
      result = shift_res;
    end else if (sel[3:2] == UNIT_ARITH) begin
      result = arith_sum;
    end else begin
      result = logic_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        out_q <= {arith_carry, result};
      end
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_reg.sv
// Self-checking bench for alu_reg: directed vector table, reset/valid sequences and
// randomized operations checked against an integer-arithmetic reference model.
module tb_alu_reg;

  localparam int unsigned SIZE = 5;
  localparam int M = 1 << SIZE;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic [3:0]      sel;
  logic [SIZE:0]   out;
  logic            out_valid;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0]      sel;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [SIZE:0]   exp;
  } vec_t;

  vec_t vecs[16];

  alu_reg #(
    .SIZE(SIZE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .out      (out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [SIZE:0] act, input logic [SIZE:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Reference: carry from value comparisons, result from modular integer arithmetic.
  function automatic logic [SIZE:0] model(input int av, input int bv, input int s);
    int res;
    int cy;
    int sub;
    sub = s % 4;
    case (sub)
      0:       cy = ((av + bv) >= M) ? 1 : 0;
      1:       cy = (av >= bv) ? 1 : 0;
      2:       cy = (av == M - 1) ? 1 : 0;
      default: cy = (av != 0) ? 1 : 0;
    endcase
    if (s < 4) begin
      case (sub)
        0, 1:    res = av & bv;
        2:       res = av | bv;
        default: res = av ^ bv;
      endcase
    end else if (s < 8) begin
      case (sub)
        0:       res = (av + bv) % M;
        1:       res = (av - bv + M) % M;
        2:       res = (av + 1) % M;
        default: res = (av + M - 1) % M;
      endcase
    end else begin
      res = (av / 2) | (av & (M / 2));
    end
    return (SIZE + 1)'(cy * M + res);
  endfunction

  // Drive on the falling edge, return 1 time unit after the capturing rising edge.
  task automatic op(input logic v, input logic [3:0] s, input logic [SIZE-1:0] va,
                    input logic [SIZE-1:0] vb);
    @(negedge clk);
    in_valid = v;
    sel = s;
    a = va;
    b = vb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [SIZE:0]   exp_out;
    logic [SIZE:0]   held;
    logic            rv;
    logic [3:0]      rs;
    logic [SIZE-1:0] ra;
    logic [SIZE-1:0] rb;

    vecs[0]  = '{4'b0000, 5'b01100, 5'b00110, 6'b0_00100};
    vecs[1]  = '{4'b0001, 5'b01100, 5'b00110, 6'b1_00100};
    vecs[2]  = '{4'b0010, 5'b01100, 5'b00110, 6'b0_01110};
    vecs[3]  = '{4'b0011, 5'b01100, 5'b00110, 6'b1_01010};
    vecs[4]  = '{4'b0100, 5'b01100, 5'b00110, 6'b0_10010};
    vecs[5]  = '{4'b0101, 5'b01100, 5'b00110, 6'b1_00110};
    vecs[6]  = '{4'b0110, 5'b01100, 5'b00110, 6'b0_01101};
    vecs[7]  = '{4'b0111, 5'b01100, 5'b00110, 6'b1_01011};
    vecs[8]  = '{4'b1000, 5'b01100, 5'b00110, 6'b0_00110};
    vecs[9]  = '{4'b1001, 5'b01100, 5'b00110, 6'b1_00110};
    vecs[10] = '{4'b1110, 5'b01100, 5'b00110, 6'b0_00110};
    vecs[11] = '{4'b1111, 5'b01100, 5'b00110, 6'b1_00110};
    vecs[12] = '{4'b1000, 5'b10101, 5'b00000, 6'b0_11010};
    vecs[13] = '{4'b0110, 5'b11111, 5'b00110, 6'b1_00000};
    vecs[14] = '{4'b0111, 5'b00000, 5'b00110, 6'b0_11111};
    vecs[15] = '{4'b0101, 5'b00011, 5'b00101, 6'b0_11110};

    rst_n = 1'b0;
    in_valid = 1'b0;
    sel = 4'b0000;
    a = '0;
    b = '0;
    @(posedge clk);
    #1;
    check("reset_out", out, '0);
    check("reset_valid", (SIZE + 1)'(out_valid), (SIZE + 1)'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      op(1'b1, vecs[i].sel, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_out", i), out, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), (SIZE + 1)'(out_valid), (SIZE + 1)'(1));
    end

    // Carry bit in every opcode, a = b so sub/dec/inc edges are exercised too.
    for (int s = 0; s < 16; s++) begin
      op(1'b1, 4'(s), 5'b10110, 5'b10110);
      check($sformatf("all_op%0d", s), out, model(22, 22, s));
    end

    // Hold: in_valid low with changing inputs keeps out, drops out_valid.
    op(1'b1, 4'b0100, 5'b00111, 5'b00001);
    held = out;
    check("load_before_hold", held, 6'b0_01000);
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 4'(i + 3), 5'(i * 7 + 1), 5'(i * 3 + 2));
      check($sformatf("hold%0d_out", i), out, held);
      check($sformatf("hold%0d_valid", i), (SIZE + 1)'(out_valid), (SIZE + 1)'(0));
    end

    // Reset while an operation is presented: reset wins, result discarded.
    op(1'b1, 4'b0011, 5'b11100, 5'b00111);
    check("pre_reset_out", out, 6'b1_11011);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1;
    sel = 4'b0100;
    a = 5'b10101;
    b = 5'b01010;
    @(posedge clk);
    #1;
    check("midreset_out", out, '0);
    check("midreset_valid", (SIZE + 1)'(out_valid), (SIZE + 1)'(0));
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    // Back-to-back: each cycle's result appears after the very next edge.
    for (int i = 0; i < 6; i++) begin
      ra = 5'(i * 5 + 3);
      rb = 5'(31 - i * 4);
      op(1'b1, 4'(i + 4), ra, rb);
      check($sformatf("b2b%0d", i), out, model(int'(ra), int'(rb), i + 4));
    end

    exp_out = out;
    for (int i = 0; i < 300; i++) begin
      rv = 1'($urandom_range(1));
      rs = 4'($urandom_range(15));
      ra = SIZE'($urandom_range(M - 1));
      rb = SIZE'($urandom_range(M - 1));
      op(rv, rs, ra, rb);
      if (rv) exp_out = model(int'(ra), int'(rb), int'(rs));
      check($sformatf("rand%0d_out", i), out, exp_out);
      check($sformatf("rand%0d_valid", i), (SIZE + 1)'(out_valid), (SIZE + 1)'(rv));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_reg.md
# alu_reg

Registered parameterised ALU that performs bitwise logic, add/subtract/increment/decrement and a one-bit arithmetic shift right on two SIZE-bit operands. It is selected by a 4-bit opcode and produces a SIZE-bit result plus an arithmetic carry bit. It is a leaf datapath block used wherever a small single-cycle ALU with a registered result is needed.

## Interface
- SIZE, default 5, operand width in bits (minimum 2).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands and opcode are valid this cycle.
- a  in  SIZE  operand A.
- b  in  SIZE  operand B.
- sel  in  4  opcode: sel[3:2] chooses the unit, sel[1:0] chooses the sub-operation.
- out  out  SIZE+1  out[SIZE] = arithmetic carry; out[SIZE-1:0] = result.
- out_valid  out  1  out holds the result of an accepted operation.

## Operation
- The unit is selected by sel[3:2]:
  - 00: logic unit.
  - 01: arithmetic unit.
  - 10 and 11: arithmetic shift right.
- Logic unit, by sel[1:0]:
  - 00 and 01: a & b.
  - 10: a | b.
  - 11: a ^ b.
- Arithmetic unit uses one adder, a + operand + cin, computed modulo 2^SIZE. The selection is by sel[1:0]:
  - 00: a + b, cin=0.
  - 01: a − b, implemented as a + ~b with cin=1.
  - 10: a + 1, implemented as a + 0 with cin=1.
  - 11: a − 1, implemented as a + all-ones with cin=0.
  - In general cin = sel[1] ^ sel[0].
- Carry out:
  - It is the adder carry (bit SIZE of the full sum).
  - For subtraction and decrement it is the inverted borrow: 1 means no borrow.
- Shift: result[i] = a[i+1] for i < SIZE−1, and result[SIZE−1] = a[SIZE−1] (sign kept). b is ignored.
- Carry output:
  - out[SIZE] is always the arithmetic-unit carry for the current sel[1:0], in every unit, including the logic and shift units.
  - Verification must check this bit in all 16 opcodes.
- Boundaries:
  - a = all-ones, inc: result 0, carry 1.
  - a = 0, dec: result all-ones, carry 0.
  - a < b, sub: two's-complement result, carry 0.
  - a = b, sub: result 0, carry 1.

## Timing
- Reset: on a rising clk edge with rst_n=0, out ← 0 and out_valid ← 0. Reset has priority over in_valid.
- Latency is 1 cycle. When in_valid=1 at edge N, out and out_valid=1 are visible after edge N.
- When in_valid=0 at an edge:
  - out_valid ← 0.
  - out holds its previous value.
- Throughput is one operation per cycle. There is no backpressure and no stall.
- Back-to-back operations: each edge with in_valid=1 overwrites out. There is no queueing.
- Reset asserted while an operation is in flight: that result is discarded, and out=0 after the reset edge.
- All selection and arithmetic logic is combinational between the input and the output register. No other state exists.

## Structure
- Shared package alu_reg_pkg holds:
  - unit-select constants: UNIT_LOGIC=2'b00, UNIT_ARITH=2'b01, UNIT_SHIFT=2'b1x.
  - logic sub-op constants: AND, OR, XOR.
  - arithmetic sub-op constants: ADD, SUB, INC, DEC.
- One sub-module is natural: alu_reg_arith. It is the combinational SIZE-bit add/sub/inc/dec with carry out, parameterised by SIZE.
- The logic unit, the shift and the output register live in the top.

## Test plan
- With SIZE=5, a=01100, b=00110, sweep sel 0000..0111 with in_valid=1. Required out values, one cycle later:
  - 0000 → 0_00100.
  - 0001 → 1_00100.
  - 0010 → 0_01110.
  - 0011 → 1_01010.
  - 0100 → 0_10010.
  - 0101 → 1_00110.
  - 0110 → 0_01101.
  - 0111 → 1_01011.
- Same operands, shift opcodes:
  - 1000 → 0_00110.
  - 1001 → 1_00110.
  - 1110 → 0_00110.
  - 1111 → 1_00110.
- Sign-preserving shift: a=10101, sel=1000, b=00000 → result 11010, carry 0.
- Wrap-around:
  - a=11111, sel=0110 → 1_00000.
  - a=00000, sel=0111 → 0_11111.
  - a=00011, b=00101, sel=0101 → 0_11110.
- Reset and valid handling:
  - Load any operation, then hold rst_n=0 for one edge → out=0 and out_valid=0.
  - Apply in_valid=0 with changing inputs → out holds and out_valid=0.
  - Apply in_valid=1 on consecutive cycles → one result per cycle, each at 1-cycle latency.
